universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register. It generalises the fixed 4-bit parallel-in/parallel-out register to WIDTH bits, and adds four modes: hold, shift right, shift left and parallel load. It has serial inputs and outputs at both ends, plus a shift counter that flags when a loaded word has been fully serialised. It sits on datapath edges as a serialiser/deserialiser stage and as a general storage register.

## Interface
Parameters:
- WIDTH, 4, register width in bits; legal range is 2 or more.
- RESET_VAL, 0, value of parallel_out after reset; WIDTH bits.

Ports:
- clk  in  1  rising-edge clock; the single clock for the block.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; when low the register holds regardless of mode.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- parallel_in  in  WIDTH  load data.
- ser_in_r  in  1  bit entering the MSB on a right shift.
- ser_in_l  in  1  bit entering the LSB on a left shift.
- rot  in  1  rotate request; only meaningful with USR_ROTATE_EN.
- parallel_out  out  WIDTH  register contents.
- ser_out_r  out  1  equals parallel_out[0].
- ser_out_l  out  1  equals parallel_out[WIDTH-1].
- shift_cnt  out  CNT_W  shifts since the last load or reset; CNT_W = $clog2(WIDTH+1).
- done  out  1  high while shift_cnt == WIDTH.

## Operation
- Reset (rst = 0), asynchronous:
  - parallel_out = RESET_VAL.
  - shift_cnt = 0.
  - done = 0.
  - The register stays in reset while rst is low. Reset asserted mid-shift aborts the operation immediately, with no partial update.
- Clock edge with en = 0: all state holds, including shift_cnt.
- Clock edge with en = 1:
  - 00: hold, and shift_cnt holds.
  - 01: q <= {ser_in_r, q[WIDTH-1:1]}; shift_cnt increments.
  - 10: q <= {q[WIDTH-2:0], ser_in_l}; shift_cnt increments.
  - 11: q <= parallel_in; shift_cnt <= 0.
- shift_cnt saturates at WIDTH; further shifts do not wrap it. The data still shifts, so zeros or serial fill keep entering.
- Left and right shifts share the same counter. A direction change mid-word keeps counting.
- done is a registered level, not a pulse:
  - Asserts on the edge where shift_cnt reaches WIDTH.
  - Clears on the next load or reset.
- ser_out_r and ser_out_l are combinational taps of the register, so they are glitch-free because they are sourced directly from flops.

## Timing
- Load latency: parallel_in appears on parallel_out one cycle after the edge sampling mode = 11 with en = 1.
- Shift latency: one cycle per bit. The serial input sampled at edge N is visible at the corresponding end after edge N.
- A full WIDTH-bit serialisation takes WIDTH enabled shift cycles after the load. done rises on the same edge as the last shift.
- Back-to-back load, then immediate shift, is legal. The shift operates on the freshly loaded value on the following edge.
- Reset release is synchronous to clk through the external reset synchroniser; the block has no internal synchroniser.
- No combinational path from any input to any output.

## Configuration
- USR_ROTATE_EN, when defined:
  - rot = 1 during a right shift feeds q[0] into the MSB in place of ser_in_r.
  - rot = 1 during a left shift feeds q[WIDTH-1] into the LSB in place of ser_in_l.
  - Rotates count toward shift_cnt like ordinary shifts.
- Without the macro:
  - rot is ignored.
  - The serial inputs are always used.
  - The port remains present so instantiations are unchanged.

## Structure
- Shared package usr_pkg holds:
  - The mode enum (USR_HOLD, USR_SHR, USR_SHL, USR_LOAD) as a 2-bit typedef.
  - The CNT_W helper function.
- One sub-module, usr_shift_counter, is the natural split. It is a saturating counter with clear, increment and limit inputs, and it produces shift_cnt and done. The top level holds the data register and the mode mux.

## Test plan
All scenarios use WIDTH = 4 and RESET_VAL = 0.
- Reset: rst low, then high with en = 0 → parallel_out = 0000, shift_cnt = 0, done = 0. Assert rst mid-sequence after loading 1010 → parallel_out = 0000 immediately, without waiting for a clock edge.
- Load: mode = 11, en = 1, parallel_in = 1111, then 1011, then 1100 on consecutive cycles → parallel_out follows with one-cycle latency; shift_cnt = 0 throughout.
- Right serialise: load 1011, then 4 cycles of mode = 01 with ser_in_r = 0 → ser_out_r sequence 1,1,0,1; final parallel_out = 0000; done rises on the 4th shift; a 5th shift keeps shift_cnt = 4.
- Left deserialise: load 0000, then shift left with ser_in_l = 1,1,0,0 → parallel_out = 1100, done = 1; a following load clears done to 0.
- Enable and hold: load 0110, then mode = 01 with en = 0 for 3 cycles, then mode = 00 with en = 1 → parallel_out stays 0110 and shift_cnt stays 0.
- Rotate, with USR_ROTATE_EN defined: load 1000, then right shift with rot = 1 for 4 cycles → sequence 0100, 0010, 0001, 1000, with done = 1. Without the macro, the same stimulus with ser_in_r = 0 ends at 0000.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the shift-counter width helper.
package usr_pkg;

    // Operating modes, matching the 2-bit mode port encoding
    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_e;

    // Counter must represent 0..width inclusive
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating shift counter. Counts increments since the last clear, stops at
// i_limit, and raises a registered done level while the count sits at the limit.
module usr_shift_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_done;
    logic             w_done_next;

    // Next count: clear wins over increment; increments stop at the limit
    always_comb begin
        w_cnt_next  = r_cnt;
        w_done_next = r_done;
        if (i_clr) begin
            w_cnt_next  = '0;
            w_done_next = 1'b0;
        end else if (i_inc) begin
            if (r_cnt < i_limit) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
            w_done_next = (w_cnt_next == i_limit);
        end
    end

    // Count and done state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_done <= w_done_next;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with serial taps at both ends and a saturating shift counter.
// Optional feature macro: USR_ROTATE_EN (rot selects end-around fill on shifts).
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    localparam int unsigned         CNT_W     = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             rot,
    output logic [WIDTH-1:0] parallel_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_fill_r;
    logic             w_fill_l;
    logic             w_clr;
    logic             w_inc;
    usr_mode_e        w_mode;

    assign w_mode = usr_mode_e'(mode);

`ifdef USR_ROTATE_EN
    // Rotation recirculates the outgoing end bit instead of the serial input
    assign w_fill_r = rot ? r_q[0]       : ser_in_r;
    assign w_fill_l = rot ? r_q[WIDTH-1] : ser_in_l;
`else
    assign w_fill_r = ser_in_r;
    assign w_fill_l = ser_in_l;
    // rot stays on the port list so instantiations are build-independent
    logic w_rot_unused;
    assign w_rot_unused = rot;
`endif

    // Mode mux: next register value plus counter clear/increment requests
    always_comb begin
        w_q_next = r_q;
        w_clr    = 1'b0;
        w_inc    = 1'b0;
        if (en) begin
            unique case (w_mode)
                USR_HOLD: begin
                    w_q_next = r_q;
                end
                USR_SHR: begin
                    w_q_next = {w_fill_r, r_q[WIDTH-1:1]};
                    w_inc    = 1'b1;
                end
                USR_SHL: begin
                    w_q_next = {r_q[WIDTH-2:0], w_fill_l};
                    w_inc    = 1'b1;
                end
                USR_LOAD: begin
                    w_q_next = parallel_in;
                    w_clr    = 1'b1;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    // Data register, forced to RESET_VAL while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    usr_shift_counter #(
        .CNT_W (CNT_W)
    ) u_shift_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_limit (CntLimit),
        .o_cnt   (shift_cnt),
        .o_done  (done)
    );

    // Serial taps come straight from flops
    assign parallel_out = r_q;
    assign ser_out_r    = r_q[0];
    assign ser_out_l    = r_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH = 4, RESET_VAL = 0).
// A behavioural model tracks the register as an integer; a negedge process
// compares every cycle, and directed scenarios pin literal values.
module tb_universal_shift_reg;

    localparam int W     = 4;
    localparam int CW    = 3;
    localparam int MASK  = (1 << W) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  parallel_in;
    logic          ser_in_r;
    logic          ser_in_l;
    logic          rot;
    logic [W-1:0]  parallel_out;
    logic          ser_out_r;
    logic          ser_out_l;
    logic [CW-1:0] shift_cnt;
    logic          done;

    universal_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .parallel_in  (parallel_in),
        .ser_in_r     (ser_in_r),
        .ser_in_l     (ser_in_l),
        .rot          (rot),
        .parallel_out (parallel_out),
        .ser_out_r    (ser_out_r),
        .ser_out_l    (ser_out_l),
        .shift_cnt    (shift_cnt),
        .done         (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_on = 0;

    // Behavioural model state
    int m_q    = 0;
    int m_cnt  = 0;
    bit m_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q    = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    task automatic model_edge(input bit e, input int m, input int p, input bit sr,
                              input bit sl, input bit r);
        int fill;
        if (!rst) begin
            model_reset();
            return;
        end
        if (!e) return;
        case (m)
            1: begin
                fill = sr;
`ifdef USR_ROTATE_EN
                if (r) fill = m_q & 1;
`endif
                m_q = (m_q >> 1) | (fill << (W - 1));
            end
            2: begin
                fill = sl;
`ifdef USR_ROTATE_EN
                if (r) fill = (m_q >> (W - 1)) & 1;
`endif
                m_q = ((m_q << 1) | fill) & MASK;
            end
            3: m_q = p & MASK;
            default: ;
        endcase
        if (m == 3) begin
            m_cnt  = 0;
            m_done = 0;
        end else if (m == 1 || m == 2) begin
            if (m_cnt < W) m_cnt++;
            m_done = (m_cnt == W);
        end
    endtask

    // Drive one cycle, advance the model on the edge, return just after it
    task automatic step(input bit e, input int m, input int p, input bit sr,
                        input bit sl, input bit r);
        en          = e;
        mode        = m[1:0];
        parallel_in = p[W-1:0];
        ser_in_r    = sr;
        ser_in_l    = sl;
        rot         = r;
        @(posedge clk);
        model_edge(e, m, p, sr, sl, r);
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_on) begin
            check("cyc_parallel_out", 32'(parallel_out), m_q);
            check("cyc_ser_out_r", 32'(ser_out_r), m_q & 1);
            check("cyc_ser_out_l", 32'(ser_out_l), (m_q >> (W - 1)) & 1);
            check("cyc_shift_cnt", 32'(shift_cnt), m_cnt);
            check("cyc_done", 32'(done), 32'(m_done));
        end
    end

    initial begin
        int ser_exp[4];
        int left_in[4];
        int rot_exp[4];
        ser_exp = '{1, 1, 0, 1};
        left_in = '{1, 1, 0, 0};
`ifdef USR_ROTATE_EN
        rot_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
`else
        rot_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};
`endif
        rst = 1'b0; en = 1'b0; mode = 2'b00; parallel_in = '0;
        ser_in_r = 1'b0; ser_in_l = 1'b0; rot = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_on = 1;

        // Reset state with en low
        step(0, 0, 0, 0, 0, 0);
        check("reset_q", 32'(parallel_out), 0);
        check("reset_cnt", 32'(shift_cnt), 0);
        check("reset_done", 32'(done), 0);

        // Back-to-back loads
        step(1, 3, 4'b1111, 0, 0, 0);
        check("load_1111", 32'(parallel_out), 4'b1111);
        step(1, 3, 4'b1011, 0, 0, 0);
        check("load_1011", 32'(parallel_out), 4'b1011);
        step(1, 3, 4'b1100, 0, 0, 0);
        check("load_1100", 32'(parallel_out), 4'b1100);
        check("load_cnt", 32'(shift_cnt), 0);

        // Right serialise
        step(1, 3, 4'b1011, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("ser_r_bit", 32'(ser_out_r), ser_exp[i]);
            check("ser_r_done_early", 32'(done), 0);
            step(1, 1, 0, 0, 0, 0);
        end
        check("ser_r_final", 32'(parallel_out), 0);
        check("ser_r_cnt", 32'(shift_cnt), 4);
        check("ser_r_done", 32'(done), 1);
        step(1, 1, 0, 0, 0, 0);
        check("ser_r_saturate", 32'(shift_cnt), 4);

        // Left deserialise
        step(1, 3, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 2, 0, 0, left_in[i][0], 0);
        check("deser_l_q", 32'(parallel_out), 4'b1100);
        check("deser_l_done", 32'(done), 1);
        step(1, 3, 4'b0101, 0, 0, 0);
        check("load_clears_done", 32'(done), 0);
        check("load_clears_cnt", 32'(shift_cnt), 0);

        // Enable low and hold mode
        step(1, 3, 4'b0110, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        check("hold_q", 32'(parallel_out), 4'b0110);
        check("hold_cnt", 32'(shift_cnt), 0);

        // Rotate request on right shifts
        step(1, 3, 4'b1000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 1);
            check("rot_seq", 32'(parallel_out), rot_exp[i]);
        end
        check("rot_done", 32'(done), 1);

        // Asynchronous reset mid-sequence
        step(1, 3, 4'b1010, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_q", 32'(parallel_out), 0);
        check("async_rst_cnt", 32'(shift_cnt), 0);
        check("async_rst_done", 32'(done), 0);
        step(1, 3, 4'b1111, 0, 0, 0);
        check("rst_held_q", 32'(parallel_out), 0);
        @(negedge clk);
        rst = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
